// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: four-digit multiplexed BCD display scanner with a
// shadow register so a newly written value only appears at a frame boundary.
//
// Parameters:
//   PRESCALE  clk cycles per digit slot (2..65535)
//
// Ports:
//   clk    in   system clock, rising-edge
//   rst_n  in   asynchronous active-low reset
//   wr     in   one-cycle strobe, captures din into the shadow register
//   din    in   [15:0] four packed BCD digits, [3:0] = digit 0
//   en     in   display enable; 0 turns all digit selects off
//   pend   out  captured data is waiting for the next frame end
//   an     out  [3:0] one-hot active-low digit select
//   bcd    out  [3:0] digit nibble for an external decoder, 4'hF = blank
//
// Build option:
//   SEG7_SCAN_LZB_EN  when defined, leading zeros on digits 3..1 are blanked

module seg7_scan_ctrl #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic [15:0] din,
    input  logic        en,
    output logic        pend,
    output logic [3:0]  an,
    output logic [3:0]  bcd
);

    localparam logic [15:0] CNT_MAX = 16'(PRESCALE - 1);

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [1:0]  idx_n;
    logic        tick;
    logic        fend;
    logic        load;
    logic        live;
    logic [15:0] shadow;
    logic [15:0] disp;
    logic [15:0] disp_n;

    // One slot ends when the prescaler reaches its last count.
    assign tick   = (cnt == CNT_MAX);
    assign idx_n  = idx + 2'd1;

    // The 3 -> 0 step closes a frame; only there may disp change.
    assign fend   = tick && (idx == 2'd3);

    // A write landing on the frame end wins: it refreshes shadow and
    // the transfer waits one more frame.
    assign load   = fend && pend && !wr;
    assign disp_n = load ? shadow : disp;

    function automatic logic [3:0] sel(input logic [1:0] k);
        sel = ~(4'b0001 << k);
    endfunction

    function automatic logic [3:0] digit(
        input logic [15:0] d,
        input logic [1:0]  k
    );
        logic [3:0] nib;
        logic       blank;
        nib   = d[{k, 2'b00} +: 4];
        blank = (nib > 4'd9);
`ifdef SEG7_SCAN_LZB_EN
        // A digit is a leading zero when it and all digits above it are 0.
        // Digit 0 is always shown so a value of zero still reads "0".
        case (k)
            2'd3:    blank = blank || (d[15:12] == 4'd0);
            2'd2:    blank = blank || (d[15:8] == 8'd0);
            2'd1:    blank = blank || (d[15:4] == 12'd0);
            default: blank = blank;
        endcase
`endif
        digit = blank ? 4'hF : nib;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 16'd0;
            idx    <= 2'd3;
            shadow <= 16'hFFFF;
            disp   <= 16'hFFFF;
            pend   <= 1'b0;
            an     <= 4'b1111;
            bcd    <= 4'hF;
            live   <= 1'b0;
        end else begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;

            if (tick) begin
                idx  <= idx_n;
                live <= 1'b1;
                // Use the post-load display so the new frame starts clean.
                bcd  <= digit(disp_n, idx_n);
            end

            if (load) begin
                disp <= shadow;
                pend <= 1'b0;
            end

            if (wr) begin
                shadow <= din;
                pend   <= 1'b1;
            end

            // en is honoured every cycle; re-enabling resumes at the
            // current slot. Before the first tick nothing is selected.
            if (!en) begin
                an <= 4'b1111;
            end else if (tick) begin
                an <= sel(idx_n);
            end else if (live) begin
                an <= sel(idx);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl.
// A slot-level reference model predicts outputs every cycle; a monitor compares.

module tb_seg7_scan_ctrl;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr;
    logic [15:0] din;
    logic        en;
    logic        pend;
    logic [3:0]  an;
    logic [3:0]  bcd;

    seg7_scan_ctrl #(.PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr),
        .din   (din),
        .en    (en),
        .pend  (pend),
        .an    (an),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       p;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: cycles since reset release, shadow, display, pending.
    int          cyc;
    logic [15:0] m_sh;
    logic [15:0] m_disp;
    logic        m_pend;

    function automatic logic [3:0] ref_digit(input logic [15:0] d, input int k);
        int unsigned dv;
        int unsigned v;
        dv = d;
        v  = (dv >> (4 * k)) % 16;
        if (v > 9) return 4'hF;
`ifdef SEG7_SCAN_LZB_EN
        if (k > 0 && (dv >> (4 * k)) == 0) return 4'hF;
`endif
        return 4'(v);
    endfunction

    task automatic check(input string nm, input exp_t act, input exp_t e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t: got pend=%0b an=%b bcd=%h, expected pend=%0b an=%b bcd=%h",
                     nm, $time, act.p, act.a, act.b, e.p, e.a, e.b);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        m_sh   = 16'hFFFF;
        m_disp = 16'hFFFF;
        m_pend = 1'b0;
    endtask

    // Model: slot k after reset shows digit (3+k)%4; a frame end is the
    // slot boundary that lands on digit 0.
    always @(posedge clk) begin
        exp_t e;
        int   id;
        bit   fe;
        if (!rst_n) begin
            model_reset();
            e = '{p: 1'b0, a: 4'hF, b: 4'hF};
        end else begin
            cyc++;
            id = (3 + cyc / P) % 4;
            fe = (cyc % P == 0) && (id == 0);
            if (fe && m_pend && !wr) begin
                m_disp = m_sh;
                m_pend = 1'b0;
            end
            if (wr) begin
                m_sh   = din;
                m_pend = 1'b1;
            end
            e.p = m_pend;
            e.a = (en && cyc >= P) ? ~(4'b0001 << id) : 4'hF;
            e.b = ref_digit(m_disp, id);
        end
        q.push_back(e);
    end

    // Asynchronous reset drops any prediction made before it.
    always @(negedge rst_n) begin
        model_reset();
        q.delete();
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("scan", {pend, an, bcd}, e);
        end
    end

    task automatic step(input logic w, input logic [15:0] d, input logic e);
        @(negedge clk);
        wr  = w;
        din = d;
        en  = e;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, din, en);
    endtask

    // Returns at the negedge right before a frame-end clock edge.
    task automatic to_frame_end();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((cyc + 1) % (4 * P) != P && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_end_wait: no frame end within 100 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        wr    = 1'b0;
        din   = 16'h0000;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hold", {pend, an, bcd}, '{p: 1'b0, a: 4'hF, b: 4'hF});
        rst_n = 1'b1;

        // Plain scan with a blank display.
        idle(8 * P);

        // Load mid-frame.
        idle(2);
        step(1'b1, 16'h1234, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        idle(10 * P);

        // Write exactly on the frame-end edge.
        to_frame_end();
        wr  = 1'b1;
        din = 16'h5678;
        step(1'b0, 16'h0000, 1'b1);
        idle(10 * P);

        // Invalid digit and zero digits.
        step(1'b1, 16'h00A7, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        idle(10 * P);

        // Back-to-back writes: only the last one survives.
        step(1'b1, 16'h9999, 1'b1);
        step(1'b1, 16'h4321, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        idle(10 * P);

        // Display off then on again mid-frame.
        step(1'b0, 16'h0000, 1'b0);
        idle(3 * P + 1);
        step(1'b0, 16'h0000, 1'b1);
        idle(5 * P);

        // Asynchronous reset while data is pending.
        step(1'b1, 16'h8888, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {pend, an, bcd}, '{p: 1'b0, a: 4'hF, b: 4'hF});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(10 * P);

        // Randomised traffic, including some writes on frame ends.
        for (int i = 0; i < 60; i++) begin
            for (int j = 0; j < 12; j++) begin
                step(($urandom_range(0, 9) == 0), 16'($urandom),
                     ($urandom_range(0, 7) != 0));
            end
            if ($urandom_range(0, 3) == 0) begin
                to_frame_end();
                wr  = 1'b1;
                din = 16'($urandom);
                step(1'b0, din, en);
            end
        end

        idle(4 * P);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000, giving clk cycles per digit slot (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port wr  input  1  one-cycle strobe that captures din.
REQ-005 SHALL have port din  input  16  four packed BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-006 SHALL have port en  input  1  display enable; 0 turns all digits off.
REQ-007 SHALL have port pend  output  1  high while captured data waits for the next frame boundary.
REQ-008 SHALL have port an  output  4  one-hot, active-low digit select.
REQ-009 SHALL have port bcd  output  4  nibble for the external BCD-to-7-segment decoder; 4'hF means blank.

Function
REQ-010 SHALL keep a prescale counter cnt that counts 0..PRESCALE-1 and wraps to 0; tick is asserted when cnt==PRESCALE-1.
REQ-011 SHALL hold a 2-bit digit index idx that advances on each tick, wrapping from 3 to 0.
REQ-012 SHALL treat a frame end as the tick that moves idx from 3 to 0.
REQ-013 SHALL register an and bcd on each tick to reflect the new idx value, so both outputs change on the same edge.
REQ-014 SHALL drive an with a 0 at bit idx and 1 elsewhere when en=1, and 4'b1111 when en=0.
REQ-015 SHALL evaluate en every cycle, and the scan SHALL continue while en=0.
REQ-016 SHALL drive bcd as nibble idx of the display register disp; any nibble greater than 9 SHALL be output as 4'hF.
REQ-017 SHALL load din into a shadow register when wr=1, and pend SHALL rise on the next edge (latency 1).
REQ-018 SHALL, at a frame end with pend=1 and wr=0, copy shadow into disp and clear pend.
REQ-019 SHALL take the bcd driven at that frame-end tick from the newly loaded disp.
REQ-020 SHALL, when wr coincides with a frame end, capture din into shadow, leave disp unchanged and keep pend=1.
REQ-021 SHALL, on back-to-back wr strobes before a frame end, keep only the last din; earlier values are never displayed.
REQ-022 SHALL NOT let disp change except at a frame end, so a frame is never torn.

Reset
REQ-023 SHALL, while rst_n=0, force cnt=0, idx=3, shadow=16'hFFFF, disp=16'hFFFF, pend=0, an=4'b1111 and bcd=4'hF, regardless of clk.
REQ-024 SHALL, after rst_n is released, make the first tick select digit 0 and count it as a frame end.
REQ-025 SHALL, when reset is asserted mid-frame or while pend=1, discard pending data with no partial update.

Configuration
REQ-026 SHALL compile leading-zero blanking in when macro SEG7_SCAN_LZB_EN is defined.
REQ-027 SHALL, with SEG7_SCAN_LZB_EN defined, output bcd=4'hF for digit k (k=3,2,1) when disp digit k and every more-significant digit equal 0.
REQ-028 SHALL, with SEG7_SCAN_LZB_EN defined, never blank digit 0 by this rule.
REQ-029 SHALL, without SEG7_SCAN_LZB_EN, display zeros as 4'h0 and contain no blanking logic.

Verification
REQ-030 SHALL cover reset and scan (PRESCALE=4, en=1, no wr): an sequence 1111 -> 1110 -> 1101 -> 1011 -> 0111 -> 1110, each step 4 cycles apart; bcd=F throughout.
REQ-031 SHALL cover a basic load: wr with din=16'h1234 mid-frame -> pend=1 next cycle; at the next frame end pend=0, and the following four slots give bcd=4,3,2,1.
REQ-032 SHALL cover wr at a frame end: wr din=16'h5678 exactly at the 3->0 tick -> disp unchanged that frame, pend stays 1, 8,7,6,5 appear the frame after.
REQ-033 SHALL cover invalid digits and blanking: din=16'h00A7 with SEG7_SCAN_LZB_EN -> bcd 7,F,F,F; without the macro -> 7,F,0,0.
REQ-034 SHALL cover en and asynchronous reset: en=0 -> an=1111 while idx keeps advancing, and en=1 resumes at the current idx; rst_n low between clock edges with pend=1 -> all outputs take reset values immediately.
